// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, PC sequencing states and bus-strobe bit positions
// used by the program counter and the control sequencer.
package cpu_pkg;

   localparam int unsigned CPU_DATA_W = 8;
   localparam int unsigned CPU_ADDR_W = 16;
   localparam logic [15:0] CPU_RESET_VEC = 16'h0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIX_UP = 2'd1,
      FIX_DN = 2'd2
   } pc_state_t;

   // Bit positions of the PC bus-drive strobes within the sequencer's strobe word.
   localparam int unsigned STB_PCL_DB  = 0;
   localparam int unsigned STB_PCH_DB  = 1;
   localparam int unsigned STB_PCL_ABL = 2;
   localparam int unsigned STB_PCH_ABH = 3;
   localparam int unsigned STB_W       = 4;

endpackage

// File: rtl/pc_half_adder.sv
// DATA_W+1-bit adder: unsigned PC half plus sign-extended offset, returning the low
// DATA_W bits and the unsigned carry out of bit DATA_W-1.
module pc_half_adder
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = CPU_DATA_W
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_sum,
   output logic              o_carry
);

   logic [DATA_W:0] w_sum;

   assign w_sum = {1'b0, i_a} + {i_b[DATA_W-1], i_b};
   assign o_sum = w_sum[DATA_W-1:0];
   // The sign-extension bit flips the top bit, so undo it to recover the plain carry.
   assign o_carry = w_sum[DATA_W] ^ i_b[DATA_W-1];

endmodule

// File: rtl/pc_unit.sv
// Program counter split into low/high halves: increment, per-half load, and relative
// branch with a one-cycle high-half fix-up when the branch leaves the current page.
module pc_unit
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = CPU_DATA_W,
   parameter int unsigned ADDR_W = CPU_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(CPU_RESET_VEC)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_pci,
   input  logic                     i_br,
   input  logic                     i_abl_pcl,
   input  logic                     i_abh_pch,
   input  logic                     i_pcl_db,
   input  logic                     i_pch_db,
   input  logic                     i_pcl_abl,
   input  logic                     i_pch_abh,
   input  logic [DATA_W-1:0]        i_db_in,
   input  logic [DATA_W-1:0]        i_abl_in,
   input  logic [ADDR_W-DATA_W-1:0] i_abh_in,
   output logic [ADDR_W-1:0]        o_pc,
   output logic [DATA_W-1:0]        o_db_out,
   output logic                     o_db_oe,
   output logic [DATA_W-1:0]        o_abl_out,
   output logic                     o_abl_oe,
   output logic [ADDR_W-DATA_W-1:0] o_abh_out,
   output logic                     o_abh_oe,
   output logic                     o_busy,
   output logic                     o_page_cross
);

   localparam int unsigned HI_W = ADDR_W - DATA_W;

   logic [DATA_W-1:0] r_pcl, w_pcl_d;
   logic [HI_W-1:0]   r_pch, w_pch_d;
   pc_state_t         r_state, w_state_d;

   logic [DATA_W-1:0] w_br_sum;
   logic              w_br_carry;
   logic              w_off_neg;
   logic [ADDR_W-1:0] w_pc_inc;

   pc_half_adder #(
      .DATA_W (DATA_W)
   ) u_br_add (
      .i_a     (r_pcl),
      .i_b     (i_db_in),
      .o_sum   (w_br_sum),
      .o_carry (w_br_carry)
   );

   assign w_off_neg = i_db_in[DATA_W-1];
   assign w_pc_inc  = {r_pch, r_pcl} + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcl   <= RESET_VEC[DATA_W-1:0];
         r_pch   <= RESET_VEC[ADDR_W-1:DATA_W];
         r_state <= IDLE;
      end else begin
         r_pcl   <= w_pcl_d;
         r_pch   <= w_pch_d;
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_pcl_d   = r_pcl;
      w_pch_d   = r_pch;
      w_state_d = r_state;
      unique case (r_state)
         IDLE: begin
            if (i_abl_pcl || i_abh_pch) begin
               if (i_abl_pcl) w_pcl_d = i_abl_in;
               if (i_abh_pch) w_pch_d = i_abh_in;
            end else if (i_br) begin
               w_pcl_d = w_br_sum;
               // Leaving the page needs a second cycle to step the high half.
               if (!w_off_neg && w_br_carry) begin
                  w_state_d = FIX_UP;
               end else if (w_off_neg && !w_br_carry) begin
                  w_state_d = FIX_DN;
               end
            end else if (i_pci) begin
               {w_pch_d, w_pcl_d} = w_pc_inc;
            end
         end
         FIX_UP: begin
            w_pch_d   = r_pch + HI_W'(1);
            w_state_d = IDLE;
         end
         FIX_DN: begin
            w_pch_d   = r_pch - HI_W'(1);
            w_state_d = IDLE;
         end
         default: w_state_d = IDLE;
      endcase
   end

   assign o_pc         = {r_pch, r_pcl};
   assign o_busy       = (r_state != IDLE);
   assign o_page_cross = (r_state != IDLE);

   always_comb begin
      o_db_out = '0;
      if (i_pcl_db) begin
         o_db_out = r_pcl;
      end else if (i_pch_db) begin
         o_db_out = DATA_W'(r_pch);
      end
   end

   assign o_db_oe   = i_pcl_db | i_pch_db;
   assign o_abl_out = r_pcl;
   assign o_abl_oe  = i_pcl_abl;
   assign o_abh_out = r_pch;
   assign o_abh_oe  = i_pch_abh;

endmodule

// File: tb/tb_pc_unit.sv
// Directed test of pc_unit: a 16-bit instance and a 12-bit instance sharing stimulus.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        pci, br, abl_pcl, abh_pch, pcl_db, pch_db, pcl_abl, pch_abh;
   logic [7:0]  db_in, abl_in, abh_in;

   logic [15:0] pc_a;
   logic [7:0]  db_out_a, abl_out_a, abh_out_a;
   logic        db_oe_a, abl_oe_a, abh_oe_a, busy_a, pcross_a;

   logic [11:0] pc_b;
   logic [7:0]  db_out_b, abl_out_b;
   logic [3:0]  abh_out_b;
   logic        db_oe_b, abl_oe_b, abh_oe_b, busy_b, pcross_b;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   pc_unit #(
      .DATA_W    (8),
      .ADDR_W    (16),
      .RESET_VEC (16'hFFFC)
   ) u_dut_a (
      .clk          (clk),
      .rst          (rst),
      .i_pci        (pci),
      .i_br         (br),
      .i_abl_pcl    (abl_pcl),
      .i_abh_pch    (abh_pch),
      .i_pcl_db     (pcl_db),
      .i_pch_db     (pch_db),
      .i_pcl_abl    (pcl_abl),
      .i_pch_abh    (pch_abh),
      .i_db_in      (db_in),
      .i_abl_in     (abl_in),
      .i_abh_in     (abh_in),
      .o_pc         (pc_a),
      .o_db_out     (db_out_a),
      .o_db_oe      (db_oe_a),
      .o_abl_out    (abl_out_a),
      .o_abl_oe     (abl_oe_a),
      .o_abh_out    (abh_out_a),
      .o_abh_oe     (abh_oe_a),
      .o_busy       (busy_a),
      .o_page_cross (pcross_a)
   );

   pc_unit #(
      .DATA_W    (8),
      .ADDR_W    (12),
      .RESET_VEC (12'hFFC)
   ) u_dut_b (
      .clk          (clk),
      .rst          (rst),
      .i_pci        (pci),
      .i_br         (br),
      .i_abl_pcl    (abl_pcl),
      .i_abh_pch    (abh_pch),
      .i_pcl_db     (pcl_db),
      .i_pch_db     (pch_db),
      .i_pcl_abl    (pcl_abl),
      .i_pch_abh    (pch_abh),
      .i_db_in      (db_in),
      .i_abl_in     (abl_in),
      .i_abh_in     (abh_in[3:0]),
      .o_pc         (pc_b),
      .o_db_out     (db_out_b),
      .o_db_oe      (db_oe_b),
      .o_abl_out    (abl_out_b),
      .o_abl_oe     (abl_oe_b),
      .o_abh_out    (abh_out_b),
      .o_abh_oe     (abh_oe_b),
      .o_busy       (busy_b),
      .o_page_cross (pcross_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      pci = 0; br = 0; abl_pcl = 0; abh_pch = 0;
      pcl_db = 0; pch_db = 0; pcl_abl = 0; pch_abh = 0;
      db_in = '0; abl_in = '0; abh_in = '0;
   endtask

   task automatic load(input logic [7:0] hi, input logic [7:0] lo);
      clr();
      abl_pcl = 1; abl_in = lo; abh_pch = 1; abh_in = hi;
      tick();
      clr();
   endtask

   task automatic branch(input logic [7:0] off);
      clr();
      br = 1; db_in = off;
      tick();
      clr();
   endtask

   initial begin
      clr();
      rst = 1;
      tick();
      chk("rst_pc", pc_a, 32'hFFFC);
      chk("rst_busy", busy_a, 0);
      chk("rst_pcross", pcross_a, 0);
      chk("rst_pc_b", pc_b, 32'hFFC);
      rst = 0;

      pci = 1;
      tick(); chk("inc1", pc_a, 32'hFFFD);
      tick(); chk("inc2", pc_a, 32'hFFFE);
      tick(); chk("inc3", pc_a, 32'hFFFF);
      tick(); chk("inc_wrap", pc_a, 32'h0000);
      clr();

      // Load with a simultaneous drive shows the old value first.
      abl_pcl = 1; abl_in = 8'h34; abh_pch = 1; abh_in = 8'h12; pcl_db = 1;
      #1;
      chk("rmw_old_db", db_out_a, 32'h00);
      chk("rmw_db_oe", db_oe_a, 1);
      tick();
      chk("load_pc", pc_a, 32'h1234);
      abl_pcl = 0; abh_pch = 0;
      #1;
      chk("drive_pcl_db", db_out_a, 32'h34);
      pcl_db = 0; pch_abh = 1; pcl_abl = 1;
      #1;
      chk("drive_abh", abh_out_a, 32'h12);
      chk("drive_abh_oe", abh_oe_a, 1);
      chk("drive_abl", abl_out_a, 32'h34);
      chk("drive_abl_oe", abl_oe_a, 1);
      chk("db_oe_off", db_oe_a, 0);
      pcl_db = 1; pch_db = 1;
      #1;
      chk("db_prio", db_out_a, 32'h34);
      pcl_db = 0;
      #1;
      chk("drive_pch_db", db_out_a, 32'h12);
      chk("drive_pch_db_b", db_out_b, 32'h02);
      clr();

      load(8'h12, 8'h10);
      branch(8'h05);
      chk("br_fwd_pc", pc_a, 32'h1215);
      chk("br_fwd_busy", busy_a, 0);
      branch(8'hF0);
      chk("br_back_pc", pc_a, 32'h1205);
      chk("br_back_busy", busy_a, 0);

      // Forward page cross; commands during the fix-up cycle are ignored.
      load(8'h12, 8'hF0);
      branch(8'h20);
      chk("xup1_pc", pc_a, 32'h1210);
      chk("xup1_busy", busy_a, 1);
      chk("xup1_pcross", pcross_a, 1);
      pci = 1; abl_pcl = 1; abl_in = 8'h77; pch_abh = 1;
      #1;
      chk("xup1_abh", abh_out_a, 32'h12);
      tick();
      clr();
      chk("xup2_pc", pc_a, 32'h1310);
      chk("xup2_busy", busy_a, 0);
      chk("xup2_pcross", pcross_a, 0);

      load(8'h12, 8'h05);
      branch(8'hF0);
      chk("xdn1_pc", pc_a, 32'h12F5);
      chk("xdn1_busy", busy_a, 1);
      tick();
      chk("xdn2_pc", pc_a, 32'h11F5);
      chk("xdn2_busy", busy_a, 0);

      load(8'h00, 8'h05);
      branch(8'hF0);
      chk("xdnw1_pc", pc_a, 32'h00F5);
      tick();
      chk("xdnw2_pc", pc_a, 32'hFFF5);

      // Reset during fix-up discards the pending high-half step.
      load(8'h12, 8'h05);
      branch(8'hF0);
      chk("xrst1_busy", busy_a, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("xrst_pc", pc_a, 32'hFFFC);
      chk("xrst_busy", busy_a, 0);
      chk("xrst_pcross", pcross_a, 0);
      tick();
      chk("xrst_hold", pc_a, 32'hFFFC);

      abl_pcl = 1; abl_in = 8'h40; br = 1; db_in = 8'h10; pci = 1;
      tick();
      clr();
      chk("prio_lo", pc_a, 32'hFF40);
      chk("prio_busy", busy_a, 0);
      abh_pch = 1; abh_in = 8'h56; pci = 1;
      tick();
      clr();
      chk("prio_hi", pc_a, 32'h5640);

      // 12-bit instance: 4-bit high half.
      rst = 1;
      tick();
      rst = 0;
      chk("b_rst", pc_b, 32'hFFC);
      load(8'h0F, 8'hF0);
      chk("b_load", pc_b, 32'hFF0);
      branch(8'h20);
      chk("b_xup1", pc_b, 32'hF10);
      chk("b_xup1_busy", busy_b, 1);
      chk("b_xup1_pcross", pcross_b, 1);
      pch_abh = 1;
      #1;
      chk("b_xup1_abh", abh_out_b, 32'hF);
      chk("b_xup1_abh_oe", abh_oe_b, 1);
      tick();
      clr();
      chk("b_xup2", pc_b, 32'h010);
      chk("b_xup2_busy", busy_b, 0);
      load(8'h0F, 8'hFF);
      pci = 1; pcl_abl = 1;
      #1;
      chk("b_abl", abl_out_b, 32'hFF);
      chk("b_abl_oe", abl_oe_b, 1);
      tick();
      clr();
      chk("b_inc_wrap", pc_b, 32'h000);
      load(8'h00, 8'h05);
      branch(8'hF0);
      chk("b_xdn1", pc_b, 32'h0F5);
      tick();
      chk("b_xdn2", pc_b, 32'hFF5);
      pcl_db = 1;
      #1;
      chk("b_db", db_out_b, 32'hF5);
      chk("b_db_oe", db_oe_b, 1);
      clr();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter, successor to the fixed 8+8-bit PC.
- Holds an ADDR_W-bit PC split into a low half (DATA_W bits) and a high half (ADDR_W-DATA_W bits).
- Supports increment, per-half load from the address buses, and signed relative branch with a multi-cycle page-crossing fix-up.
- Sits between the control sequencer and the DB/ABL/ABH buses in the CPU top. Drives buses through output-enable strobes; the top level resolves the tristates.

Parameters:
- DATA_W, 8: data bus width and PC low-half width.
- ADDR_W, 16: total PC width. Legal range DATA_W+1 .. 2*DATA_W. HI_W = ADDR_W-DATA_W.
- RESET_VEC, 16'h0000: PC value loaded on reset; ADDR_W bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- pci  in  1  increment PC by 1.
- br  in  1  relative branch; offset taken from db_in.
- abl_pcl  in  1  load PC low half from abl_in.
- abh_pch  in  1  load PC high half from abh_in.
- pcl_db  in  1  drive PC low half onto DB.
- pch_db  in  1  drive PC high half onto DB.
- pcl_abl  in  1  drive PC low half onto ABL.
- pch_abh  in  1  drive PC high half onto ABH.
- db_in  in  DATA_W  DB value; two's-complement branch offset.
- abl_in  in  DATA_W  ABL value for load.
- abh_in  in  HI_W  ABH value for load.
- pc  out  ADDR_W  current PC, registered.
- db_out  out  DATA_W  DB drive value.
- db_oe  out  1  DB drive enable.
- abl_out  out  DATA_W  ABL drive value.
- abl_oe  out  1
- abh_out  out  HI_W  ABH drive value.
- abh_oe  out  1
- busy  out  1  fix-up cycle in progress; sequencer must stall.
- page_cross  out  1  one-cycle pulse, asserted during the fix-up cycle.

Behaviour:
- Reset: clk and rst as named; reset is synchronous, active-high.
  - pc=RESET_VEC, state=IDLE, busy=0, page_cross=0.
  - rst overrides every command, including mid-fix-up; the pending fix-up is discarded.
- State machine states: IDLE, FIX_UP, FIX_DN.
- IDLE command priority:
  - Loads first. abl_pcl and abh_pch are independent; both in one cycle loads the full PC.
  - If any load is asserted, br and pci are ignored that cycle.
  - Else br: sum = {0,pcl} + sext(db_in) over DATA_W+1 bits; pcl <= sum[DATA_W-1:0].
    - Offset >= 0 and carry out: next state FIX_UP.
    - Offset < 0 and no carry out (borrow): next state FIX_DN.
    - Otherwise stay in IDLE; pch unchanged. Branch latency is 1 cycle.
  - Else pci: pc <= pc+1 across the full width with carry into pch. Wraps all-ones -> 0. Latency 1 cycle.
- FIX_UP: pch <= pch+1, wrapping mod 2^HI_W; next state IDLE. Page-crossing branch latency is 2 cycles.
- FIX_DN: pch <= pch-1, wrapping; next state IDLE.
- busy and page_cross: both are combinational from state; both equal 1 exactly in FIX_UP/FIX_DN.
- Commands during busy: pci, br and loads are ignored.
- Bus outputs (combinational):
  - db_out = pcl if pcl_db, else zero-extended pch if pch_db, else 0.
  - db_oe = pcl_db | pch_db. pcl_db wins if both are set; this is a sequencer error, but the output is deterministic.
  - abl_out = pcl, abl_oe = pcl_abl.
  - abh_out = pch, abh_oe = pch_abh.
  - Bus outputs are valid during busy and show the intermediate PC.
- Read-modify-write: a load on the same cycle as a drive returns the old value on the bus; the new value appears the next cycle.
- Branch offset range: -2^(DATA_W-1) .. 2^(DATA_W-1)-1, relative to the current PC. The caller pre-increments PC if required.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and ADDR_W defaults.
  - pc_state_t enum {IDLE, FIX_UP, FIX_DN}.
  - RESET_VEC default.
  - Bus-strobe bundle constant names shared with the sequencer.
- One natural sub-module, pc_half_adder: a DATA_W+1-bit adder with sign extension, returning sum and carry. It is reused by the low-half branch path.
- The high-half ±1 stays inline.

Test Plan:
- Reset: rst=1 for one edge, RESET_VEC=16'hFFFC -> pc=FFFC, busy=0. Then pci x4 -> pc FFFD, FFFE, FFFF, 0000 (wrap).
- Load and drive: abl_pcl=1,abl_in=34 together with abh_pch=1,abh_in=12 -> pc=1234 next cycle. pcl_db=1 -> db_out=34, db_oe=1. pch_abh=1 -> abh_out=12, abh_oe=1.
- Branch within page: pc=1210, br, db_in=05 -> pc=1215 after 1 cycle, busy never 1. db_in=F0 (-16) from 1215 -> 1205.
- Forward page cross: pc=12F0, br, db_in=20 -> cycle 1 pc=1210, busy=1, page_cross=1; cycle 2 pc=1310, busy=0. A pci asserted during cycle 1 is ignored.
- Backward page cross and mid-fix-up reset: pc=1205, br, db_in=F0 -> pc=12F5, busy=1, then 11F5. Repeat with pc=0005, db_in=F0 -> 00F5 then FFF5 (high wrap). Repeat with rst asserted in the fix-up cycle -> pc=RESET_VEC, busy=0.
- Priority and parameters: abl_pcl+br+pci in one cycle -> only the load takes effect. Re-run all scenarios with ADDR_W=12, DATA_W=8: FIX_UP from pc=FF0 with db_in=20 -> 010 (4-bit high wrap).
